// File: rtl/dcm_meter.sv
// dcm_meter: measures the period of the divider's slow clock in clk cycles
// and classifies it as one of eight modes (PERIOD_BASE << k, k = 0..7).
// clk_in is sampled as asynchronous data; it never clocks any flop here.
module dcm_meter #(
    parameter int unsigned PERIOD_BASE = 10000000,
    parameter int unsigned TOL         = 1000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_in,
    output logic [2:0]  prog_meas,
    output logic        locked,
    output logic        meas_valid,
    output logic        prog_change,
    output logic [31:0] period,
    output logic        stall
);

    localparam logic [31:0] BASE    = 32'(PERIOD_BASE);
    localparam logic [31:0] TOL32   = 32'(TOL);
    localparam logic [31:0] TIMEOUT = BASE << 8;
    localparam logic [31:0] CNT_MAX = '1;
    // Fewer than two stages would not resolve metastability.
    localparam int unsigned SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {StIdle, StMeas, StStall} state_e;

    state_e            state_q, state_d;
    logic [SYNC_N-1:0] sync_q;
    logic              sync_prev_q;
    logic              edge_evt;
    logic [31:0]       cnt_q, cnt_d;
    logic              timeout;

    logic [31:0]       meas_per;
    logic [31:0]       target;
    logic [31:0]       diff;
    logic              match;
    logic [2:0]        match_k;

    logic [2:0]        prog_q, prog_d;
    logic              locked_q, locked_d;
    logic              valid_q, valid_d;
    logic              change_q, change_d;
    logic [31:0]       period_q, period_d;
    logic              stall_q, stall_d;

    // Synchronizer chain plus one delayed copy for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_N-2:0], clk_in};
            sync_prev_q <= sync_q[SYNC_N-1];
        end
    end

    assign edge_evt = sync_q[SYNC_N-1] & ~sync_prev_q;
    assign timeout  = (cnt_q >= TIMEOUT);

    // Period counter: restarts on every edge event, otherwise counts up and saturates
    always_comb begin
        if (edge_evt) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Classify the period ending at this edge; scanning down leaves the lowest match
    always_comb begin
        // An edge on the timeout cycle reports exactly TIMEOUT, which no mode can match.
        meas_per = timeout ? TIMEOUT : cnt_q + 32'd1;
        match    = 1'b0;
        match_k  = '0;
        target   = '0;
        diff     = '0;
        for (int k = 7; k >= 0; k--) begin
            target = BASE << k;
            diff   = (meas_per >= target) ? meas_per - target : target - meas_per;
            if (diff <= TOL32) begin
                match   = 1'b1;
                match_k = 3'(k);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; an edge always wins over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (edge_evt) begin
                    state_d = StMeas;
                end else if (timeout) begin
                    state_d = StStall;
                end
            end
            StMeas: begin
                if (!edge_evt && timeout) begin
                    state_d = StStall;
                end
            end
            StStall: begin
                if (edge_evt) begin
                    state_d = StMeas;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM output logic: next values of the registered reporting outputs
    always_comb begin
        prog_d   = prog_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        change_d = 1'b0;
        period_d = period_q;
        stall_d  = stall_q;
        case (state_q)
            StIdle: begin
                // The first edge only sets the reference point.
                if (!edge_evt && timeout) begin
                    stall_d  = 1'b1;
                    locked_d = 1'b0;
                end
            end
            StMeas: begin
                if (edge_evt) begin
                    valid_d  = 1'b1;
                    period_d = meas_per;
                    if (match) begin
                        locked_d = 1'b1;
                        prog_d   = match_k;
                        change_d = (match_k != prog_q);
                    end else begin
                        locked_d = 1'b0;
                    end
                end else if (timeout) begin
                    stall_d  = 1'b1;
                    locked_d = 1'b0;
                end
            end
            StStall: begin
                // Recovery edge is a reference only; no measurement.
                if (edge_evt) begin
                    stall_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_q   <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
            period_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            prog_q   <= prog_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            change_q <= change_d;
            period_q <= period_d;
            stall_q  <= stall_d;
        end
    end

    assign prog_meas   = prog_q;
    assign locked      = locked_q;
    assign meas_valid  = valid_q;
    assign prog_change = change_q;
    assign period      = period_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_dcm_meter.sv
// Bench for dcm_meter: drives clk_in with rising edges a known number of clk
// cycles apart and checks each reported measurement against a gap-list model.
module tb_dcm_meter;

    localparam int unsigned PB = 20;
    localparam int unsigned TL = 2;
    localparam int unsigned SS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_in = 1'b0;
    logic [2:0]  prog_meas;
    logic        locked;
    logic        meas_valid;
    logic        prog_change;
    logic [31:0] period;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    // Gaps (in clk cycles) between successive clk_in rises for the next burst
    int gaps_q[$];
    // Measurement pulses seen on the outputs
    int cap_per[$];
    int cap_lock[$];
    int cap_prog[$];
    int cap_chg[$];
    // Model expectations
    int exp_per[$];
    int exp_lock[$];
    int exp_prog[$];
    int exp_chg[$];
    logic mv_prev = 1'b0;

    dcm_meter #(
        .PERIOD_BASE(PB),
        .TOL        (TL),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_in     (clk_in),
        .prog_meas  (prog_meas),
        .locked     (locked),
        .meas_valid (meas_valid),
        .prog_change(prog_change),
        .period     (period),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Record every measurement pulse and check pulse shape
    always @(negedge clk) begin
        if (meas_valid) begin
            cap_per.push_back(int'(period));
            cap_lock.push_back(int'(locked));
            cap_prog.push_back(int'(prog_meas));
            cap_chg.push_back(int'(prog_change));
        end
        if (meas_valid || prog_change) begin
            n_checks++;
            if ((prog_change && !meas_valid) || (meas_valid && mv_prev)) begin
                n_fail++;
                $display("FAIL pulse_shape: meas_valid=%0b prev=%0b prog_change=%0b, want single-cycle with coincident prog_change",
                         meas_valid, mv_prev, prog_change);
            end
        end
        mv_prev = meas_valid;
    end

    // Mode k if |g - PB*2^k| <= TL for the lowest such k
    function automatic void classify(input int g, output bit ok, output int k);
        int tgt;
        int dev;
        ok = 1'b0;
        k  = 0;
        for (int m = 0; m < 8; m++) begin
            tgt = int'(PB) * (1 << m);
            dev = (g > tgt) ? g - tgt : tgt - g;
            if (!ok && dev <= int'(TL)) begin
                ok = 1'b1;
                k  = m;
            end
        end
    endfunction

    // Expected reports for a burst that follows a reset (prog starts at 0)
    function automatic void build_expect();
        bit ok;
        int k;
        int prog;
        prog = 0;
        exp_per.delete();
        exp_lock.delete();
        exp_prog.delete();
        exp_chg.delete();
        foreach (gaps_q[i]) begin
            classify(gaps_q[i], ok, k);
            exp_per.push_back(gaps_q[i]);
            if (ok) begin
                exp_chg.push_back((k != prog) ? 1 : 0);
                prog = k;
                exp_lock.push_back(1);
            end else begin
                exp_chg.push_back(0);
                exp_lock.push_back(0);
            end
            exp_prog.push_back(prog);
        end
    endfunction

    function automatic void clear_cap();
        cap_per.delete();
        cap_lock.delete();
        cap_prog.delete();
        cap_chg.delete();
    endfunction

    task automatic do_reset(input logic level);
        rst    = 1'b1;
        clk_in = level;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_cap();
    endtask

    // One reference rise followed by one rise per entry of gaps_q
    task automatic send_rises();
        @(negedge clk);
        clk_in = 1'b1;
        foreach (gaps_q[i]) begin
            repeat (gaps_q[i] / 2) @(negedge clk);
            clk_in = 1'b0;
            repeat (gaps_q[i] - gaps_q[i] / 2) @(negedge clk);
            clk_in = 1'b1;
        end
        repeat (10) @(negedge clk);
        clk_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_checks++;
        if ({prog_meas, locked, meas_valid, prog_change, period, stall} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_values: got prog=%0d lock=%0b mv=%0b chg=%0b per=%0d stall=%0b, want all 0",
                     prog_meas, locked, meas_valid, prog_change, period, stall);
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (cap_per.size() !== 0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: got pulses=%0d stall=%0b, want 0 and 0", cap_per.size(), stall);
        end
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        gaps_q = {20, 20, 20};
        build_expect();
        send_rises();
        n_checks++;
        if (cap_per.size() !== exp_per.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d pulses, want %0d", cap_per.size(), exp_per.size());
        end
        for (int i = 0; i < exp_per.size() && i < cap_per.size(); i++) begin
            n_checks++;
            if (cap_per[i] !== exp_per[i] || cap_lock[i] !== exp_lock[i] ||
                cap_prog[i] !== exp_prog[i] || cap_chg[i] !== exp_chg[i]) begin
                n_fail++;
                $display("FAIL basic_meas[%0d]: got per=%0d lock=%0d prog=%0d chg=%0d, want per=%0d lock=%0d prog=%0d chg=%0d",
                         i, cap_per[i], cap_lock[i], cap_prog[i], cap_chg[i],
                         exp_per[i], exp_lock[i], exp_prog[i], exp_chg[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset(1'b0);
        // 1000 stands in for the period straddling the divider switch.
        gaps_q = {160, 160, 1000, 2560, 2560};
        build_expect();
        send_rises();
        n_checks++;
        if (cap_per.size() !== exp_per.size()) begin
            n_fail++;
            $display("FAIL switch_count: got %0d pulses, want %0d", cap_per.size(), exp_per.size());
        end
        for (int i = 0; i < exp_per.size() && i < cap_per.size(); i++) begin
            n_checks++;
            if (cap_per[i] !== exp_per[i] || cap_lock[i] !== exp_lock[i] ||
                cap_prog[i] !== exp_prog[i] || cap_chg[i] !== exp_chg[i]) begin
                n_fail++;
                $display("FAIL switch_meas[%0d]: got per=%0d lock=%0d prog=%0d chg=%0d, want per=%0d lock=%0d prog=%0d chg=%0d",
                         i, cap_per[i], cap_lock[i], cap_prog[i], cap_chg[i],
                         exp_per[i], exp_lock[i], exp_prog[i], exp_chg[i]);
            end
        end
    endtask

    task automatic test_tolerance();
        do_reset(1'b0);
        gaps_q = {21, 18, 23, 38, 37, 42};
        build_expect();
        send_rises();
        n_checks++;
        if (cap_per.size() !== exp_per.size()) begin
            n_fail++;
            $display("FAIL tol_count: got %0d pulses, want %0d", cap_per.size(), exp_per.size());
        end
        for (int i = 0; i < exp_per.size() && i < cap_per.size(); i++) begin
            n_checks++;
            if (cap_per[i] !== exp_per[i] || cap_lock[i] !== exp_lock[i] ||
                cap_prog[i] !== exp_prog[i] || cap_chg[i] !== exp_chg[i]) begin
                n_fail++;
                $display("FAIL tol_meas[%0d]: got per=%0d lock=%0d prog=%0d chg=%0d, want per=%0d lock=%0d prog=%0d chg=%0d",
                         i, cap_per[i], cap_lock[i], cap_prog[i], cap_chg[i],
                         exp_per[i], exp_lock[i], exp_prog[i], exp_chg[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        gaps_q = {20, 20};
        send_rises();
        n_checks++;
        if (locked !== 1'b1 || prog_meas !== 3'd0) begin
            n_fail++;
            $display("FAIL stall_prelock: got lock=%0b prog=%0d, want 1 and 0", locked, prog_meas);
        end
        // Counted from the last rise: 15 cycles already elapsed.
        repeat (5085) @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_early: got stall=%0b at 5100 idle cycles, want 0", stall);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || locked !== 1'b0 || prog_meas !== 3'd0 || period !== 32'd20) begin
            n_fail++;
            $display("FAIL stall_set: got stall=%0b lock=%0b prog=%0d per=%0d, want 1 0 0 20",
                     stall, locked, prog_meas, period);
        end
        repeat (6000 - 5140) @(negedge clk);
        clear_cap();
        clk_in = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || cap_per.size() !== 0) begin
            n_fail++;
            $display("FAIL stall_clear: got stall=%0b pulses=%0d, want 0 and 0", stall, cap_per.size());
        end
        repeat (14) @(negedge clk);
        clk_in = 1'b0;
        repeat (20) @(negedge clk);
        clk_in = 1'b1;
        repeat (8) @(negedge clk);
        clk_in = 1'b0;
        n_checks++;
        if (cap_per.size() !== 1) begin
            n_fail++;
            $display("FAIL stall_recover_count: got %0d pulses, want 1", cap_per.size());
        end else if (cap_per[0] !== 40 || cap_lock[0] !== 1 || cap_prog[0] !== 1 || cap_chg[0] !== 1) begin
            n_fail++;
            $display("FAIL stall_recover: got per=%0d lock=%0d prog=%0d chg=%0d, want 40 1 1 1",
                     cap_per[0], cap_lock[0], cap_prog[0], cap_chg[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        gaps_q = {640, 640};
        send_rises();
        n_checks++;
        if (locked !== 1'b1 || prog_meas !== 3'd5) begin
            n_fail++;
            $display("FAIL rstmid_prelock: got lock=%0b prog=%0d, want 1 and 5", locked, prog_meas);
        end
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({prog_meas, locked, meas_valid, prog_change, period, stall} !== 39'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got prog=%0d lock=%0b mv=%0b chg=%0b per=%0d stall=%0b, want all 0",
                     prog_meas, locked, meas_valid, prog_change, period, stall);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_cap();
        gaps_q = {640};
        build_expect();
        send_rises();
        n_checks++;
        if (cap_per.size() !== 1) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d pulses, want 1", cap_per.size());
        end else if (cap_per[0] !== exp_per[0] || cap_lock[0] !== exp_lock[0] ||
                     cap_prog[0] !== exp_prog[0] || cap_chg[0] !== exp_chg[0]) begin
            n_fail++;
            $display("FAIL rstmid_meas: got per=%0d lock=%0d prog=%0d chg=%0d, want per=%0d lock=%0d prog=%0d chg=%0d",
                     cap_per[0], cap_lock[0], cap_prog[0], cap_chg[0],
                     exp_per[0], exp_lock[0], exp_prog[0], exp_chg[0]);
        end
    endtask

    task automatic test_stuck_high();
        do_reset(1'b1);
        repeat (5100) @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_early: got stall=%0b at cycle 5100, want 0", stall);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || locked !== 1'b0 || cap_per.size() !== 0) begin
            n_fail++;
            $display("FAIL stuck_stall: got stall=%0b lock=%0b pulses=%0d, want 1 0 0",
                     stall, locked, cap_per.size());
        end
        clk_in = 1'b0;
    endtask

    task automatic test_random();
        int mode;
        int jit;
        do_reset(1'b0);
        gaps_q.delete();
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                gaps_q.push_back(int'($urandom_range(18, 300)));
            end else begin
                mode = int'($urandom_range(0, 6));
                jit  = int'($urandom_range(0, 6)) - 3;
                gaps_q.push_back(int'(PB) * (1 << mode) + jit);
            end
        end
        build_expect();
        send_rises();
        n_checks++;
        if (cap_per.size() !== exp_per.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d pulses, want %0d", cap_per.size(), exp_per.size());
        end
        for (int i = 0; i < exp_per.size() && i < cap_per.size(); i++) begin
            n_checks++;
            if (cap_per[i] !== exp_per[i] || cap_lock[i] !== exp_lock[i] ||
                cap_prog[i] !== exp_prog[i] || cap_chg[i] !== exp_chg[i]) begin
                n_fail++;
                $display("FAIL rand_meas[%0d]: got per=%0d lock=%0d prog=%0d chg=%0d, want per=%0d lock=%0d prog=%0d chg=%0d",
                         i, cap_per[i], cap_lock[i], cap_prog[i], cap_chg[i],
                         exp_per[i], exp_lock[i], exp_prog[i], exp_chg[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mode_switch();
        test_tolerance();
        test_stall();
        test_reset_mid();
        test_stuck_high();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcm_meter.md
# dcm_meter

Frequency meter for the slow clock produced by the clock divider. It recovers which of the eight divider modes is running by measuring the period of `clk_2` and reports that mode. It sits beside the divider in the 100 MHz domain, and the bench uses it to confirm that an `update`/`prog_in` request produced the intended frequency. `clk_in` is treated as asynchronous data, never as a clock.

## Interface

Parameters:
- `PERIOD_BASE`, default 10000000: full period of mode 0 (10 Hz) in `clk` cycles. Mode k period is `PERIOD_BASE << k`, for k = 0..7.
- `TOL`, default 1000: allowed deviation in cycles for a mode match.
- `SYNC_STAGES`, default 2: synchronizer depth on `clk_in`, minimum 2.

Ports:
- `clk`  in  1  100 MHz reference clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_in`  in  1  slow clock under measurement (divider `clk_2`).
- `prog_meas`  out  3  last successfully classified mode.
- `locked`  out  1  high while the last completed period matched a mode.
- `meas_valid`  out  1  one-cycle pulse per completed period measurement.
- `prog_change`  out  1  one-cycle pulse, coincident with `meas_valid`, when a match gives a mode different from the previous `prog_meas`.
- `period`  out  32  last raw measured period, in `clk` cycles.
- `stall`  out  1  high when no rising edge arrived within the timeout.

## Operation

Input path:
- `clk_in` passes through a `SYNC_STAGES` flip-flop synchronizer and then a rising-edge detector.
- An "edge event" is one `clk` cycle where the synchronized value is 1 and the previous value was 0.

Counter:
- 32-bit counter `cnt`. It is 0 on the cycle after each edge event and increments every other cycle.
- Saturates at 2^32-1 and never wraps.
- `TIMEOUT` = `PERIOD_BASE << 8` (twice the mode-7 period). It must fit in 32 bits; the default gives 2.56e9.

FSM states:
- **IDLE** (reset state):
  - An edge event starts the counter and moves to MEAS. No measurement is reported.
  - If `cnt` reaches `TIMEOUT`, move to STALL.
- **MEAS**, on an edge event:
  - `period <= cnt+1`, `meas_valid` pulses, and the counter restarts.
  - Classify the period:
    - Match when |period − (`PERIOD_BASE<<k`)| ≤ `TOL` for some k. Take the lowest such k.
    - On a match: `locked<=1` and `prog_meas<=k`. `prog_change` pulses if k differs from the old `prog_meas`.
    - No match: `locked<=0`, `prog_meas` holds, no `prog_change`.
  - If `cnt` reaches `TIMEOUT` with no edge event, move to STALL.
- **STALL**:
  - `stall=1`, `locked=0`, `prog_meas` and `period` hold.
  - An edge event clears `stall`, restarts the counter and moves to MEAS.
  - That first edge is a reference only; no `meas_valid` is produced.

Arithmetic:
- The deviation is computed as an unsigned difference with the larger operand first. No signed overflow is allowed.
- Shifts are done at 32 bits.

Boundary conditions:
- Edge event on the same cycle `cnt` reaches `TIMEOUT`: the edge wins. The measurement is made with period = `TIMEOUT`; it cannot match, so `locked=0`. The FSM stays in MEAS.
- Mode change mid-run: the period that straddles the divider switch is classified normally. It will usually mismatch, giving `locked=0` for one period. The next full period matches the new mode.
- `rst` at any time: all state clears asynchronously and the FSM enters IDLE. The first edge after reset is discarded.
- Glitches shorter than one `clk` cycle may be lost. That is acceptable.

## Timing

- Reset values: `prog_meas`=0, `locked`=0, `meas_valid`=0, `prog_change`=0, `period`=0, `stall`=0. Synchronizer and counter are also 0.
- Latency:
  - An edge event occurs `SYNC_STAGES`+1 `clk` edges after a `clk_in` rise that is set up before a `clk` edge.
  - `meas_valid`, `period`, `locked`, `prog_meas` and `prog_change` update on the `clk` edge following the edge event.
  - All of these outputs are registered.
- A `clk_in` stimulus whose rising edges are exactly N `clk` cycles apart yields `period`=N.
- `stall` asserts on the cycle after `cnt` reaches `TIMEOUT`. It deasserts on the cycle after the next edge event.
- `meas_valid` and `prog_change` are strictly one cycle wide. There is no back-pressure.

## Test plan

All scenarios use `PERIOD_BASE`=20, `TOL`=2, `SYNC_STAGES`=2, so `TIMEOUT`=5120.

1. Reset, then `clk_in` toggling with period 20 for 4 periods -> first edge gives no pulse. Then three `meas_valid` pulses, each with `period`=20, `locked`=1, `prog_meas`=0; no `prog_change`.
2. Period 160, then switch to period 2560 -> at 160: `prog_meas`=3 with one `prog_change`. Transition period: `locked`=0 if it mismatches. Then `prog_meas`=7, `locked`=1, one `prog_change`.
3. Periods 21, 18 and 23 -> 21: match mode 0. 18: match mode 0 (deviation 2). 23: `locked`=0, `prog_meas` stays 0, `period`=23.
4. `clk_in` held low for 6000 cycles after locking -> `stall`=1 after 5120 idle cycles, `locked`=0. Next rise: `stall`=0, no `meas_valid`. The following period-40 edge gives `prog_meas`=1.
5. Assert `rst` mid-period while locked on mode 5 -> all outputs 0 immediately. First post-reset edge produces no pulse; the second gives a valid measurement.
6. `clk_in` stuck high from reset -> `stall`=1 at cycle 5121 after reset release; no `meas_valid` ever.
